// File: rtl/spi_slave_pkg.sv
// Shared definitions for the parametrised SPI slave: command encodings and FSM states.
package spi_slave_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    RX      = 3'd2,
    WAIT_TX = 3'd3,
    TX      = 3'd4
  } state_e;

endpackage

// File: rtl/spi_shreg.sv
// MSB-first shift register shared by the receive and transmit paths of the SPI slave.
module spi_shreg
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              shift_in_i,
  output logic [DATA_W-1:0] data_o,
  output logic              shift_out_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = {data_q[DATA_W-2:0], shift_in_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // Word as it will look once the current serial bit is in; lets the frame complete on its last edge.
  assign data_o      = {data_q[DATA_W-2:0], shift_in_i};
  assign shift_out_o = data_q[DATA_W-1];

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front-end for the single-port RAM: 2-bit command + DATA_W payload frames,
// read-response with timeout, abort/sequence error pulses and a fixed idle MISO level.
//
// state   | meaning
// IDLE    | waiting for SS_n low; first low edge captures cmd[1]
// CMD     | capturing cmd[0]
// RX      | shifting in DATA_W payload bits
// WAIT_TX | RD_DATA received, waiting for tx_valid or timeout
// TX      | shifting read data out on MISO
module spi_slave_param
  import spi_slave_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter int   TX_TIMEOUT = 16,
  parameter logic MISO_IDLE  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W+1:0] rx_data,
  output logic              busy,
  output logic              frame_err,
  output logic              seq_err
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam int TO_W = $clog2(TX_TIMEOUT + 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TX_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              miso_q, miso_d;
  logic [DATA_W+1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              seq_err_q, seq_err_d;
  logic              addr_seen_q, addr_seen_d;

  logic              sh_load;
  logic              sh_shift;
  logic [DATA_W-1:0] sh_data;
  logic              sh_out;

  spi_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (sh_load),
    .shift_i     (sh_shift),
    .load_data_i ({tx_data[DATA_W-2:0], 1'b0}),
    .shift_in_i  (MOSI),
    .data_o      (sh_data),
    .shift_out_o (sh_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      miso_q      <= MISO_IDLE;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      seq_err_q   <= 1'b0;
      addr_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      seq_err_q   <= seq_err_d;
      addr_seen_q <= addr_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    seq_err_d   = 1'b0;
    addr_seen_d = addr_seen_q;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;

    // SS_n high mid-frame wins over everything else, including timeout and tx_valid.
    if (state_q != IDLE && SS_n) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      to_cnt_d    = '0;
      miso_d      = MISO_IDLE;
      frame_err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!SS_n) begin
            cmd_d   = {MOSI, cmd_q[0]};
            state_d = CMD;
          end
        end
        CMD: begin
          cmd_d     = {cmd_q[1], MOSI};
          bit_cnt_d = '0;
          state_d   = RX;
        end
        RX: begin
          sh_shift = 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            rx_data_d  = {cmd_q, sh_data};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            if (cmd_q == CMD_RD_DATA) begin
              seq_err_d   = !addr_seen_q;
              addr_seen_d = 1'b0;
              to_cnt_d    = '0;
              state_d     = WAIT_TX;
            end else begin
              if (cmd_q == CMD_RD_ADDR) begin
                addr_seen_d = 1'b1;
              end
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        WAIT_TX: begin
          if (tx_valid) begin
            sh_load   = 1'b1;
            miso_d    = tx_data[DATA_W-1];
            to_cnt_d  = '0;
            bit_cnt_d = '0;
            state_d   = TX;
          end else if (to_cnt_q == TO_LAST) begin
            frame_err_d = 1'b1;
            to_cnt_d    = '0;
            state_d     = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        TX: begin
          if (bit_cnt_q == BIT_LAST) begin
            miso_d    = MISO_IDLE;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            sh_shift  = 1'b1;
            miso_d    = sh_out;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign MISO      = miso_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign seq_err   = seq_err_q;

endmodule
